// File: rtl/clock_control_rtc.sv
// Time-of-day clock: BCD hh:mm:ss with prescaler, 12/24h display, set-mode FSM.
// Latency: registered time/TICK/CARRY; INCR/DEC act on the 3rd clock edge after rising.
// Backpressure: none; free-running, button edges outside a set state are dropped.
module clock_control_rtc #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned PRE_W    = 26
) (
  input  logic       CLOCK_CLK,
  input  logic       CLOCK_RST_N,
  input  logic       SET_SEC,
  input  logic       SET_MIN,
  input  logic       SET_HOUR,
  input  logic       INCR,
  input  logic       DEC,
  input  logic       MODE_12H,
  output logic [7:0] SECOND,
  output logic [7:0] MINUTE,
  output logic [7:0] HOUR,
  output logic       PM,
  output logic       TICK,
  output logic       CARRY
);

  typedef enum logic [1:0] {RUN, SET_S, SET_M, SET_H} state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic             tick_q, tick_d, carry_q, carry_d;
  // [0] first sync stage, [1] second sync stage, [2] previous value for edge detect
  logic [2:0]       incr_sync_q, incr_sync_d, dec_sync_q, dec_sync_d;
  logic             incr_rise, dec_rise, step_up, step_dn;
  logic [4:0]       hour_bin, disp_bin;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00) return max;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Next state: hour select dominates minute, minute dominates second.
  always_comb begin
    state_d = RUN;
    if (SET_HOUR)     state_d = SET_H;
    else if (SET_MIN) state_d = SET_M;
    else if (SET_SEC) state_d = SET_S;
  end

  // Button synchronisers shift in the raw level; rise = stage2 high, previous low.
  always_comb begin
    incr_sync_d = {incr_sync_q[1], incr_sync_q[0], INCR};
    dec_sync_d  = {dec_sync_q[1], dec_sync_q[0], DEC};
    incr_rise   = incr_sync_q[1] & ~incr_sync_q[2];
    dec_rise    = dec_sync_q[1] & ~dec_sync_q[2];
    step_up     = incr_rise & ~dec_rise;
    step_dn     = dec_rise & ~incr_rise;
  end

  // Timekeeping: ripple-carry counting in RUN, single-field wrap edits in set states.
  always_comb begin
    pre_d   = pre_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
    case (state_q)
      RUN: begin
        if (pre_q == PRE_LAST) begin
          pre_d  = '0;
          tick_d = 1'b1;
          sec_d  = bcd_inc(sec_q, 8'h59);
          if (sec_q == 8'h59) begin
            min_d = bcd_inc(min_q, 8'h59);
            if (min_q == 8'h59) begin
              hour_d = bcd_inc(hour_q, 8'h23);
              if (hour_q == 8'h23) carry_d = 1'b1;
            end
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      SET_S: begin
        pre_d = '0;
        if (step_up)      sec_d = bcd_inc(sec_q, 8'h59);
        else if (step_dn) sec_d = bcd_dec(sec_q, 8'h59);
      end
      SET_M: begin
        pre_d = '0;
        if (step_up)      min_d = bcd_inc(min_q, 8'h59);
        else if (step_dn) min_d = bcd_dec(min_q, 8'h59);
      end
      default: begin
        pre_d = '0;
        if (step_up)      hour_d = bcd_inc(hour_q, 8'h23);
        else if (step_dn) hour_d = bcd_dec(hour_q, 8'h23);
      end
    endcase
    // Seconds read 00 from the first SET_S cycle so release lands on a whole second.
    if ((state_d == SET_S) && (state_q != SET_S)) sec_d = 8'h00;
  end

  // State, time, pulse and synchroniser registers.
  always_ff @(posedge CLOCK_CLK or negedge CLOCK_RST_N) begin
    if (!CLOCK_RST_N) begin
      state_q     <= RUN;
      pre_q       <= '0;
      sec_q       <= 8'h00;
      min_q       <= 8'h00;
      hour_q      <= 8'h00;
      tick_q      <= 1'b0;
      carry_q     <= 1'b0;
      incr_sync_q <= 3'b000;
      dec_sync_q  <= 3'b000;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      tick_q      <= tick_d;
      carry_q     <= carry_d;
      incr_sync_q <= incr_sync_d;
      dec_sync_q  <= dec_sync_d;
    end
  end

  // Display hour: 24h passes through; 12h maps 0->12, 13..23 -> 1..11, PM for 12..23.
  always_comb begin
    hour_bin = 5'(hour_q[7:4]) * 5'd10 + 5'(hour_q[3:0]);
    disp_bin = hour_bin;
    if (hour_bin == 5'd0)       disp_bin = 5'd12;
    else if (hour_bin > 5'd12)  disp_bin = hour_bin - 5'd12;
    HOUR = hour_q;
    PM   = 1'b0;
    if (MODE_12H) begin
      PM = (hour_bin >= 5'd12);
      if (disp_bin >= 5'd10) HOUR = {4'd1, 4'(disp_bin - 5'd10)};
      else                   HOUR = {4'd0, disp_bin[3:0]};
    end
  end

  assign SECOND = sec_q;
  assign MINUTE = min_q;
  assign TICK   = tick_q;
  assign CARRY  = carry_q;

endmodule

// File: tb/tb_clock_control_rtc.sv
// Bench for clock_control_rtc: directed set/rollover/12h scenarios plus random stimulus.
// Every cycle all outputs are compared with an integer time-of-day reference model.
// Async reset pulses are applied mid-cycle and checked before the next edge.
module tb_clock_control_rtc;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       set_sec = 1'b0, set_min = 1'b0, set_hour = 1'b0;
  logic       incr = 1'b0, dec = 1'b0, mode_12h = 1'b0;
  logic [7:0] second, minute, hour;
  logic       pm, tick, carry;

  int n_vec = 0;
  int n_err = 0;

  // reference model: plain integer time, selected field, prescale count, button history
  int m_h, m_m, m_s, m_pre, m_sel;
  bit m_tick, m_carry;
  bit i1, i2, i3, d1, d2, d3;

  clock_control_rtc #(.TICK_DIV(TD), .PRE_W(3)) dut (
    .CLOCK_CLK(clk), .CLOCK_RST_N(rst_n),
    .SET_SEC(set_sec), .SET_MIN(set_min), .SET_HOUR(set_hour),
    .INCR(incr), .DEC(dec), .MODE_12H(mode_12h),
    .SECOND(second), .MINUTE(minute), .HOUR(hour),
    .PM(pm), .TICK(tick), .CARRY(carry)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_pre = 0; m_sel = 0;
    m_tick = 0; m_carry = 0;
    i1 = 0; i2 = 0; i3 = 0; d1 = 0; d2 = 0; d3 = 0;
  endtask

  task automatic model_edge();
    bit ir, dr;
    int nsel, d;
    ir = i2 & ~i3;
    dr = d2 & ~d3;
    nsel = set_hour ? 3 : set_min ? 2 : set_sec ? 1 : 0;
    m_tick = 0;
    m_carry = 0;
    if (m_sel == 0) begin
      if (m_pre == TD - 1) begin
        m_pre = 0;
        m_tick = 1;
        m_s++;
        if (m_s == 60) begin
          m_s = 0; m_m++;
          if (m_m == 60) begin
            m_m = 0; m_h++;
            if (m_h == 24) begin m_h = 0; m_carry = 1; end
          end
        end
      end else begin
        m_pre++;
      end
    end else begin
      m_pre = 0;
      if (ir != dr) begin
        d = ir ? 1 : -1;
        case (m_sel)
          1: m_s = (m_s + d + 60) % 60;
          2: m_m = (m_m + d + 60) % 60;
          default: m_h = (m_h + d + 24) % 24;
        endcase
      end
    end
    if (nsel == 1 && m_sel != 1) m_s = 0;
    m_sel = nsel;
    i3 = i2; i2 = i1; i1 = incr;
    d3 = d2; d2 = d1; d1 = dec;
  endtask

  task automatic check_all(input string tag);
    int eh;
    eh = m_h;
    if (mode_12h) eh = (m_h == 0) ? 12 : (m_h > 12) ? m_h - 12 : m_h;
    check_val({tag, "_sec"}, second, to_bcd(m_s));
    check_val({tag, "_min"}, minute, to_bcd(m_m));
    check_val({tag, "_hour"}, hour, to_bcd(eh));
    check_val({tag, "_pm"}, {7'b0, pm}, {7'b0, (mode_12h && m_h >= 12)});
    check_val({tag, "_tick"}, {7'b0, tick}, {7'b0, m_tick});
    check_val({tag, "_carry"}, {7'b0, carry}, {7'b0, m_carry});
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic steps(input int n, input string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic pulse(input bit up, input string tag);
    if (up) incr = 1'b1; else dec = 1'b1;
    steps(2, tag);
    incr = 1'b0; dec = 1'b0;
    steps(3, tag);
  endtask

  // called at posedge+1: drops reset mid-cycle, checks reset values, releases before next edge
  task automatic async_rst(input string tag);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_all(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    int carry_cnt, tick_with_carry, guard;
    int tgt[5]   = '{0, 11, 12, 13, 23};
    int exp_h[5] = '{8'h12, 8'h11, 8'h12, 8'h01, 8'h11};
    int exp_p[5] = '{0, 0, 1, 1, 1};

    model_reset();
    #2 check_all("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // free run: 60 ticks -> 00:01:00
    steps(240, "run");
    check_val("run60_sec", second, 8'h00);
    check_val("run60_min", minute, 8'h01);

    // set 23:59:58 using decrements, then watch the midnight rollover
    set_hour = 1'b1;
    step("seth");
    guard = 0;
    while (m_h != 23 && guard < 30) begin pulse(0, "seth"); guard++; end
    set_hour = 1'b0; set_min = 1'b1;
    step("setm");
    guard = 0;
    while (m_m != 59 && guard < 70) begin pulse(0, "setm"); guard++; end
    set_min = 1'b0; set_sec = 1'b1;
    step("sets");
    pulse(0, "sets");
    pulse(0, "sets");
    check_val("set_2359_sec", second, 8'h58);
    check_val("set_2359_hr", hour, 8'h23);
    set_sec = 1'b0;
    carry_cnt = 0; tick_with_carry = 0;
    for (int k = 0; k < 12; k++) begin
      step("roll");
      if (carry) begin carry_cnt++; if (tick) tick_with_carry++; end
    end
    check_val("roll_carry_cnt", 8'(carry_cnt), 8'd1);
    check_val("roll_carry_tick", 8'(tick_with_carry), 8'd1);

    // minute wrap down then up, no effect on hours, no carry
    set_min = 1'b1;
    step("mwrap");
    pulse(0, "mwrap");
    check_val("mdec_min", minute, 8'h59);
    check_val("mdec_hour", hour, 8'h00);
    pulse(1, "mwrap");
    check_val("minc_min", minute, 8'h00);
    set_min = 1'b0;

    // hour beats seconds; simultaneous edges cancel
    set_sec = 1'b1; set_hour = 1'b1;
    step("prio");
    pulse(1, "prio");
    check_val("prio_hour", hour, 8'h01);
    incr = 1'b1; dec = 1'b1;
    steps(2, "both");
    incr = 1'b0; dec = 1'b0;
    steps(3, "both");
    check_val("both_hour", hour, 8'h01);
    set_sec = 1'b0;

    // 12h display mapping
    mode_12h = 1'b1;
    step("m12");
    for (int t = 0; t < 5; t++) begin
      guard = 0;
      while (m_h != tgt[t] && guard < 30) begin pulse(1, "m12"); guard++; end
      check_val("m12_hour", hour, 8'(exp_h[t]));
      check_val("m12_pm", {7'b0, pm}, 8'(exp_p[t]));
      mode_12h = 1'b0;
      step("m12tog");
      mode_12h = 1'b1;
      step("m12tog");
    end

    // async reset in the middle of hour setting
    async_rst("arst");
    set_hour = 1'b0;
    steps(10, "arst_run");

    // random stimulus
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        set_sec = 1'($urandom); set_min = 1'($urandom); set_hour = 1'($urandom);
      end
      if ($urandom_range(0, 3) == 0) incr = ~incr;
      if ($urandom_range(0, 3) == 0) dec = ~dec;
      if ($urandom_range(0, 19) == 0) mode_12h = ~mode_12h;
      if ($urandom_range(0, 499) == 0) async_rst("rnd_arst");
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
